// File: rtl/serial_alu.sv
// Bit-serial ALU: one full-adder slice plus a carry flip-flop,
// operands consumed LSB-first, one bit per clock.
module serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             ov,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [1:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             arith;
    logic             abit;
    logic             bbit;
    logic             sbit;
    logic             c_next;
    logic             last;
    logic [WIDTH-1:0] res_next;

    // Single-bit slice: sum/logic bit, next carry, assembled result
    always_comb begin
        arith  = ~op_q[1];
        abit   = a_sh[0];
        bbit   = b_sh[0];
        c_next = (abit & bbit) | (abit & carry) | (bbit & carry);
        unique case (op_q)
            OP_AND:  sbit = abit & bbit;
            OP_OR:   sbit = abit | bbit;
            default: sbit = abit ^ bbit ^ carry;
        endcase
        res_next = {sbit, res_sh[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM and datapath; outputs only change on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            op_q   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            r      <= '0;
            co     <= 1'b0;
            ov     <= 1'b0;
            zero   <= 1'b1;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        a_sh   <= a;
                        b_sh   <= (op == OP_SUB) ? ~b : b;
                        carry  <= (op == OP_SUB);
                        cnt    <= '0;
                        res_sh <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= c_next;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        r     <= res_next;
                        co    <= arith & c_next;
                        ov    <= arith & (carry ^ c_next);
                        zero  <= (res_next == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu at WIDTH=4.
// Inputs are driven and outputs sampled 1 time unit after posedge.
module tb_serial_alu;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         zero;

    int vectors;
    int miscompares;

    serial_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .co    (co),
        .ov    (ov),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then drop start
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~x;
        b = ~y;
    endtask

    // Ticks until done is seen, bounded at 20
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        tick();
        tick();
        vectors++;
        if ({busy, done, r, co, ov, zero} !== {2'b00, 4'b0000, 3'b001}) begin
            $display("FAIL reset: busy=%b done=%b r=%b co=%b ov=%b zero=%b, want 0 0 0000 0 0 1",
                     busy, done, r, co, ov, zero);
            miscompares++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        int n;
        launch(2'b00, 4'b0111, 4'b0001);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL add_busy: busy=%b done=%b, want 1 0", busy, done);
            miscompares++;
        end
        tick();
        vectors++;
        if (r !== 4'b0000 || zero !== 1'b1) begin
            $display("FAIL add_hold: r=%b zero=%b, want 0000 1", r, zero);
            miscompares++;
        end
        wait_done(n);
        vectors++;
        if (n + 1 !== W) begin
            $display("FAIL add_latency: %0d, want %0d", n + 1, W);
            miscompares++;
        end
        vectors++;
        if ({busy, r, co, ov, zero} !== {1'b0, 4'b1000, 3'b010}) begin
            $display("FAIL add_0111_0001: busy=%b r=%b co=%b ov=%b zero=%b, want 0 1000 0 1 0",
                     busy, r, co, ov, zero);
            miscompares++;
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || r !== 4'b1000) begin
            $display("FAIL add_pulse: done=%b busy=%b r=%b, want 0 0 1000", done, busy, r);
            miscompares++;
        end
    endtask

    task automatic test_add_wrap();
        int n;
        launch(2'b00, 4'b1111, 4'b0001);
        wait_done(n);
        vectors++;
        if (n !== W || {r, co, ov, zero} !== {4'b0000, 3'b101}) begin
            $display("FAIL add_1111_0001: n=%0d r=%b co=%b ov=%b zero=%b, want %0d 0000 1 0 1",
                     n, r, co, ov, zero, W);
            miscompares++;
        end
        tick();
        launch(2'b00, 4'b1000, 4'b1000);
        wait_done(n);
        vectors++;
        if (n !== W || {r, co, ov, zero} !== {4'b0000, 3'b111}) begin
            $display("FAIL add_1000_1000: n=%0d r=%b co=%b ov=%b zero=%b, want %0d 0000 1 1 1",
                     n, r, co, ov, zero, W);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_sub();
        int n;
        launch(2'b01, 4'b0011, 4'b0101);
        wait_done(n);
        vectors++;
        if (n !== W || {r, co, ov, zero} !== {4'b1110, 3'b000}) begin
            $display("FAIL sub_0011_0101: n=%0d r=%b co=%b ov=%b zero=%b, want %0d 1110 0 0 0",
                     n, r, co, ov, zero, W);
            miscompares++;
        end
        tick();
        launch(2'b01, 4'b0101, 4'b0101);
        wait_done(n);
        vectors++;
        if (n !== W || {r, co, ov, zero} !== {4'b0000, 3'b101}) begin
            $display("FAIL sub_0101_0101: n=%0d r=%b co=%b ov=%b zero=%b, want %0d 0000 1 0 1",
                     n, r, co, ov, zero, W);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        launch(2'b10, 4'b1100, 4'b1010);
        wait_done(n);
        vectors++;
        if (n !== W || {r, co, ov, zero} !== {4'b1000, 3'b000}) begin
            $display("FAIL and_1100_1010: n=%0d r=%b co=%b ov=%b zero=%b, want %0d 1000 0 0 0",
                     n, r, co, ov, zero, W);
            miscompares++;
        end
        launch(2'b11, 4'b1100, 4'b1010);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_nogap: busy=%b done=%b, want 1 0", busy, done);
            miscompares++;
        end
        wait_done(n);
        vectors++;
        if (n !== W || {r, co, ov, zero} !== {4'b1110, 3'b000}) begin
            $display("FAIL or_1100_1010: n=%0d r=%b co=%b ov=%b zero=%b, want %0d 1110 0 0 0",
                     n, r, co, ov, zero, W);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        int n;
        int pulses;
        launch(2'b00, 4'b0001, 4'b0001);
        tick();
        op = 2'b11;
        a = 4'b1111;
        b = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        vectors++;
        if (n + 2 !== W || r !== 4'b0010 || co !== 1'b0) begin
            $display("FAIL ignore_busy: lat=%0d r=%b co=%b, want %0d 0010 0", n + 2, r, co, W);
            miscompares++;
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) pulses++;
        end
        vectors++;
        if (pulses !== 0 || busy !== 1'b0) begin
            $display("FAIL ignore_extra: pulses=%0d busy=%b, want 0 0", pulses, busy);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        launch(2'b00, 4'b0101, 4'b0011);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, r, zero} !== {2'b00, 4'b0000, 1'b1}) begin
            $display("FAIL reset_mid: busy=%b done=%b r=%b zero=%b, want 0 0 0000 1",
                     busy, done, r, zero);
            miscompares++;
        end
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            $display("FAIL reset_abort: active cycles=%0d, want 0", pulses);
            miscompares++;
        end
        launch(2'b00, 4'b0010, 4'b0011);
        wait_done(n);
        vectors++;
        if (n !== W || {r, co, ov, zero} !== {4'b0101, 3'b000}) begin
            $display("FAIL add_after_reset: n=%0d r=%b co=%b ov=%b zero=%b, want %0d 0101 0 0 0",
                     n, r, co, ov, zero, W);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_add_wrap();
        test_sub();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Parametrised bit-serial ALU and the next generation of the 1-bit full-adder cell.
- Processes WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder slice and a carry flip-flop.
- Supports add, subtract, AND and OR, with a start/busy/done handshake and result flags.
- Used where area matters more than latency, e.g. in lab datapaths driven by a simple controller.

Parameters:
WIDTH  8  operand/result width in bits; legal range 2..32

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only when busy=0
op     input   2      00=ADD, 01=SUB (a-b), 10=AND, 11=OR; sampled with start
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
busy   output  1      operation in progress
done   output  1      one-cycle pulse; result and flags valid
r      output  WIDTH  result; held until the next accepted start completes
co     output  1      final carry-out (ADD/SUB); 0 for AND/OR
ov     output  1      signed overflow (ADD/SUB); 0 for AND/OR
zero   output  1      1 when r == 0

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rst_n), clock is clk.
- Reset: state=IDLE. busy, done, r, co, ov = 0. zero = 1 (because r = 0). Internal shift registers, carry flip-flop and bit counter cleared.
- Reset asserted mid-operation aborts immediately. No done pulse follows; the partial result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start=1 at edge E0 -> RUN:
    - latch a, op
    - latch b, inverted when op=SUB
    - carry = 1 for SUB, else 0
    - counter = 0
    - busy=1 after E0
  - RUN, at each edge Ek for k=1..WIDTH:
    - bit k-1 of the result: ADD/SUB = a^b'^c, AND = a&b, OR = a|b
    - carry updated as majority(a, b', c); ignored for AND/OR
    - operand registers shift right
    - result register shifts in from the MSB
  - At edge E_WIDTH -> DONE:
    - r, co, ov, zero updated together
    - busy=0
    - done=1 for exactly the cycle after E_WIDTH
  - DONE with start=0 -> IDLE at the next edge; done deasserts.
- Latency: done is high WIDTH edges after the start edge. busy is high for WIDTH cycles.
- Throughput: start sampled in the DONE cycle is accepted, giving back-to-back operations with no idle gap.
- start while busy=1 is ignored. a, b and op may change freely during RUN without effect.
- ov = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. Capture the carry flip-flop value before the last update.
- SUB convention: co=1 means no borrow (a >= b unsigned).
- r, co, ov and zero change only at reset or at completion edges. They are never updated bit-by-bit at the outputs.
- op values are all defined; there is no illegal-op case.

Test Plan:
- WIDTH=4, ADD a=0111 b=0001 -> done exactly 4 cycles after the start edge; r=1000, co=0, ov=1, zero=0.
- WIDTH=4, ADD a=1111 b=0001 -> r=0000, co=1, ov=0, zero=1. Also ADD a=1000 b=1000 -> r=0000, co=1, ov=1.
- WIDTH=4, SUB a=0011 b=0101 -> r=1110, co=0, ov=0. SUB a=0101 b=0101 -> r=0000, co=1, zero=1.
- WIDTH=4, AND a=1100 b=1010 -> r=1000, co=0, ov=0. Back-to-back OR with the same operands, start held in the DONE cycle -> r=1110, done again 4 cycles later, busy with no gap.
- start pulsed with a=0001 b=0001 ADD, then start re-asserted with different operands two cycles later -> second request ignored; r=0010; only one done pulse.
- rst_n dropped for one cycle in the third RUN cycle -> busy=0, done=0, r=0, zero=1 immediately, with no done pulse afterwards. A fresh ADD 0010+0011 -> r=0101.
